// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the bit-serial adder.
// master drives start/a/b/cin(/sub); slave returns busy/done/sum/cout.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add, one bit per clock via a 1-bit full adder.
// Ports: clk, rst_n (async, active-low), bus (serial_adder_if.slave):
//   start/a/b/cin in, busy/done/sum/cout out. WIDTH legal 1..64.
// SERIAL_ADDER_SUB_EN adds bus.sub: load ~b with carry 1 for a-b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s;
  logic             c_d;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] opb_ld;
  logic             c_ld;

  // 1-bit full adder cell on the operand LSBs
  assign s   = opa_q[0] ^ opb_q[0] ^ c_q;
  assign c_d = (opa_q[0] & opb_q[0])
             | (c_q & (opa_q[0] ^ opb_q[0]));

  // new bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB
  assign acc_d = (acc_q >> 1)
               | (WIDTH'(s) << (WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // two's complement subtract: a + ~b + 1
  assign opb_ld = bus.sub ? ~bus.b : bus.b;
  assign c_ld   = bus.sub ? 1'b1 : bus.cin;
`else
  assign opb_ld = bus.b;
  assign c_ld   = bus.cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        opa_q  <= bus.a;
        opb_q  <= opb_ld;
        c_q    <= c_ld;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (state_q == RUN) begin
        opa_q <= opa_q >> 1;
        opb_q <= opb_q >> 1;
        c_q   <= c_d;
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
        // results publish only once, so no partial sums leak out
        if (last) begin
          sum_q  <= acc_d;
          cout_q <= c_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors plus handshake/reset sequences.
// Drives serial_adder (WIDTH=8) through serial_adder_if.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t         vecs[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] ta,
                       input logic [W-1:0] tb_v,
                       input logic tc,
                       input logic ts);
    bus.a   = ta;
    bus.b   = tb_v;
    bus.cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = ts;
`else
    if (ts) $display("note: sub vector in add-only build");
`endif
  endtask

  // start and pass the accepting edge, then scramble the inputs
  task automatic start_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb_v,
                          input logic tc,
                          input logic ts);
    bus.start = 1'b1;
    drive(ta, tb_v, tc, ts);
    tick();
    bus.start = 1'b0;
    drive(~ta, tb_v ^ 8'h5A, ~tc, ~ts);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  // poke: bit n set pulses start after edge n of the run
  task automatic wait_done(input logic [31:0] poke,
                           output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.done) break;
      chk("sum_hold", 64'(bus.sum), 64'(prev_sum));
      chk("cout_hold", 64'(bus.cout), 64'(prev_cout));
      if (poke[n]) begin
        bus.start = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b0);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_result(input string nm,
                              input int lat,
                              input logic [W-1:0] es,
                              input logic ec);
    chk({nm, "_lat"}, 64'(lat), 64'(W));
    chk({nm, "_done"}, 64'(bus.done), 64'd1);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, "_sum"}, 64'(bus.sum), 64'(es));
    chk({nm, "_cout"}, 64'(bus.cout), 64'(ec));
    prev_sum  = es;
    prev_cout = ec;
  endtask

  initial begin
    int  lat;
    int  lat2;
    bit  seen;

    vecs.push_back('{"add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{"ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{"zero_c",  8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{"80_80",   8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{"sub10_03", 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1});
    vecs.push_back('{"sub03_10", 8'h03, 8'h10, 1'b0, 1'b1, 8'hF3, 1'b0});
    vecs.push_back('{"sub_cin",  8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1});
    vecs.push_back('{"sub55_55", 8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    bus.start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);

    // reset state
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_done", 64'(bus.done), 64'd0);
      chk("idle_sum", 64'(bus.sum), 64'd0);
    end

    // table vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(32'd0, lat);
      check_result(vecs[i].name, lat, vecs[i].sum, vecs[i].cout);
      tick();
      chk({vecs[i].name, "_pulse"}, 64'(bus.done), 64'd0);
    end

    // start pulses mid-run are ignored
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(32'h24, lat);
    check_result("ign", lat, 8'h96, 1'b0);
    tick();
    chk("ign_noqueue_busy", 64'(bus.busy), 64'd0);
    chk("ign_noqueue_done", 64'(bus.done), 64'd0);

    // back-to-back: start during the done cycle
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(32'd0, lat);
    check_result("b2b1", lat, 8'h46, 1'b0);
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(32'd0, lat2);
    check_result("b2b2", lat2, 8'h80, 1'b0);
    chk("b2b_gap", 64'(lat2 + 1), 64'(W + 1));
    tick();

    // reset mid-operation
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_sum", 64'(bus.sum), 64'd0);
    chk("mid_rst_cout", 64'(bus.cout), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(32'd0, lat);
    check_result("after_rst", lat, 8'h46, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
